// File: rtl/dmem_pkg.sv
// Shared FSM encoding, funct3 access codes and alignment helper for the data-memory access unit.
// Consumers: dmem_lane_align, dmem_access_unit.
package dmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] alone gives the size; reserved codes land on the word case.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational data-path muxing: store byte-enable/lane replication and load byte/half
// select with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_wdata_i;
    case (st_funct3_i[1:0])
      2'b00: begin
        st_be_o    = 4'b0001 << st_addr_lo_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      2'b01: begin
        st_be_o    = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_wdata_i;
      end
    endcase
  end

  always_comb begin
    case (ld_addr_lo_i)
      2'd0:    ld_byte = ld_rdata_i[7:0];
      2'd1:    ld_byte = ld_rdata_i[15:8];
      2'd2:    ld_byte = ld_rdata_i[23:16];
      default: ld_byte = ld_rdata_i[31:24];
    endcase
    ld_half = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data_o = {24'd0, ld_byte};
      F3_HU:   ld_data_o = {16'd0, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access stage: req/ack bus master with timeout, stalls PC and RF write until done.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and pulse `misalign`.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned TO_W        = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        pc_enable,
  output logic        reg_write_load,
  output logic        bus_timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  logic [1:0]    state_q, state_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          timeout_q, timeout_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    lo_q, lo_d;
`ifdef MISALIGN_TRAP_EN
  logic          misalign_q, misalign_d;
`endif

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        access;

  assign access = mem_read | mem_write;

  dmem_lane_align u_lane_align (
    .st_funct3_i  (funct3),
    .st_addr_lo_i (addr[1:0]),
    .st_wdata_i   (wdata),
    .st_be_o      (st_be),
    .st_wdata_o   (st_wdata),
    .ld_funct3_i  (f3_q),
    .ld_addr_lo_i (lo_q),
    .ld_rdata_i   (bus_rdata),
    .ld_data_o    (ld_data)
  );

  always_comb begin
    state_d        = state_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_be_d       = bus_be_q;
    bus_wdata_d    = bus_wdata_q;
    rdata_d        = rdata_q;
    timeout_d      = 1'b0;
    cnt_d          = cnt_q;
    f3_d           = f3_q;
    lo_d           = lo_q;
    pc_enable      = 1'b1;
    reg_write_load = 1'b1;
`ifdef MISALIGN_TRAP_EN
    misalign_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          pc_enable      = 1'b0;
          reg_write_load = 1'b0;
`ifdef MISALIGN_TRAP_EN
          if (is_misaligned(funct3, addr[1:0])) begin
            state_d    = ST_DONE;
            misalign_d = 1'b1;
          end else begin
            state_d = ST_BUSY;
          end
`else
          state_d = ST_BUSY;
`endif
          // Write wins when both strobes are set.
          bus_we_d    = mem_write;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_be_d    = mem_write ? st_be : 4'b1111;
          bus_wdata_d = st_wdata;
          f3_d        = funct3;
          lo_d        = addr[1:0];
          cnt_d       = '0;
        end
      end
      ST_BUSY: begin
        pc_enable      = 1'b0;
        reg_write_load = 1'b0;
        cnt_d          = cnt_q + 1'b1;
        if (bus_ack) begin
          state_d = ST_DONE;
          if (!bus_we_q) rdata_d = ld_data;
        end else if (cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d   = ST_DONE;
          rdata_d   = '0;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
`ifdef MISALIGN_TRAP_EN
        reg_write_load = ~misalign_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
      f3_q        <= '0;
      lo_q        <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      lo_q        <= lo_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  // Request decoded from state so an async reset drops it immediately.
  assign bus_req     = (state_q == ST_BUSY);
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;
  assign rdata       = rdata_q;
  assign bus_timeout = timeout_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed cases then randomized accesses against an
// arithmetic reference model. Honours MISALIGN_TRAP_EN when defined.
module tb_dmem_access_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        pc_enable, reg_write_load, bus_timeout;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  dmem_access_unit #(.TIMEOUT_CYC(TO), .TO_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .funct3         (funct3),
    .addr           (addr),
    .wdata          (wdata),
    .rdata          (rdata),
    .pc_enable      (pc_enable),
    .reg_write_load (reg_write_load),
    .bus_timeout    (bus_timeout),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_be         (bus_be),
    .bus_wdata      (bus_wdata),
`ifdef MISALIGN_TRAP_EN
    .misalign       (misalign),
`endif
    .bus_rdata      (bus_rdata),
    .bus_ack        (bus_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Access size in bytes from funct3; reserved codes behave as words.
  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    if (sz == 1) return 4'(1 << a[1:0]);
    if (sz == 2) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz = size_of(f3);
    if (sz == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] raw);
    int sz = size_of(f3);
    longint v;
    if (sz == 4) return raw;
    v = (sz == 1) ? longint'((raw >> (8 * a[1:0])) & 32'hFF)
                  : longint'((raw >> (16 * a[1])) & 32'hFFFF);
    if (!f3[2] && sz == 1 && v >= 128)   v = v - 256;
    if (!f3[2] && sz == 2 && v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  // Runs one memory access starting just after a posedge; ack_at<0 means never acknowledge.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                        input logic [31:0] raw, input string tag);
    int cyc = 0;
    int busy = 0;
    int rwl_high = 0;
    int exp_busy;
    logic timed_out;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd; bus_rdata = raw;
    exp_busy  = (ack_at >= 0 && ack_at < TO) ? ack_at + 1 : TO;
    timed_out = !(ack_at >= 0 && ack_at < TO);
    @(negedge clk);
    while (!pc_enable && cyc < 40) begin
      if (reg_write_load) rwl_high++;
      if (bus_req) begin
        if (busy == 0) begin
          check({tag, " bus_addr"}, bus_addr, {a[31:2], 2'b00});
          check({tag, " bus_we"}, 32'(bus_we), 32'(wr));
          check({tag, " bus_be"}, 32'(bus_be), wr ? 32'(model_be(f3, a)) : 32'hF);
          if (wr) check({tag, " bus_wdata"}, bus_wdata, model_wdata(f3, wd));
        end
        bus_ack = (busy == ack_at);
        busy++;
      end
      cyc++;
      @(posedge clk); #1; bus_ack = 1'b0;
      @(negedge clk);
    end
    if (timed_out) model_rdata = 32'd0;
    else if (!wr) model_rdata = model_load(f3, a, raw);
    check({tag, " stall_cycles"}, 32'(cyc), 32'(1 + exp_busy));
    check({tag, " busy_cycles"}, 32'(busy), 32'(exp_busy));
    check({tag, " rwl_low_while_stalled"}, 32'(rwl_high), 32'd0);
    check({tag, " done_rwl"}, 32'(reg_write_load), 32'd1);
    check({tag, " done_req"}, 32'(bus_req), 32'd0);
    check({tag, " done_timeout"}, 32'(bus_timeout), 32'(timed_out));
    check({tag, " rdata"}, rdata, model_rdata);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    addr = '0; wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
    model_rdata = '0;
    #12;
    check("rst bus_req", 32'(bus_req), 32'd0);
    check("rst bus_we", 32'(bus_we), 32'd0);
    check("rst bus_be", 32'(bus_be), 32'd0);
    check("rst bus_addr", bus_addr, 32'd0);
    check("rst bus_wdata", bus_wdata, 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst timeout", 32'(bus_timeout), 32'd0);
    check("rst pc_enable", 32'(pc_enable), 32'd1);
    check("rst rwl", 32'(reg_write_load), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Non-memory instruction: single cycle, ack outside BUSY ignored.
    bus_ack = 1'b1;
    @(negedge clk);
    check("nonmem pc_enable", 32'(pc_enable), 32'd1);
    check("nonmem rwl", 32'(reg_write_load), 32'd1);
    check("nonmem bus_req", 32'(bus_req), 32'd0);
    @(posedge clk); #1; bus_ack = 1'b0;

    access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, "sw");
    access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 32'h0, "sb");
    access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 0, 32'h12F03456, "lb");
    access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 0, 32'h12F03456, "lbu");
    access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h12F03456, "lhu");
    access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 4, 32'hCAFEF00D, "lw_wait4");
    access(1'b1, 1'b1, 3'b001, 32'h302, 32'h00001234, 1, 32'h0, "rdwr_as_sh");
    access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, -1, 32'h55555555, "lw_timeout");
    @(negedge clk);
    check("timeout pulse_end", 32'(bus_timeout), 32'd0);
    check("timeout rdata_hold", rdata, 32'd0);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 0, 32'h89ABCDEF, "lw_prime");

    // Reset mid-BUSY.
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h600;
    @(posedge clk); #1;
    @(posedge clk); #3;
    check("midrst busy_before", 32'(bus_req), 32'd1);
    rst = 1'b0; #1;
    check("midrst bus_req", 32'(bus_req), 32'd0);
    check("midrst rdata", rdata, 32'd0);
    check("midrst timeout", 32'(bus_timeout), 32'd0);
    mem_read = 1'b0; #1;
    check("midrst pc_enable", 32'(pc_enable), 32'd1);
    model_rdata = 32'd0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

`ifdef MISALIGN_TRAP_EN
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h101;
    @(negedge clk);
    check("mis idle_pc", 32'(pc_enable), 32'd0);
    @(negedge clk);
    check("mis pulse", 32'(misalign), 32'd1);
    check("mis rwl", 32'(reg_write_load), 32'd0);
    check("mis pc", 32'(pc_enable), 32'd1);
    check("mis bus_req", 32'(bus_req), 32'd0);
    @(posedge clk); #1; mem_read = 1'b0;
    @(negedge clk);
    check("mis pulse_end", 32'(misalign), 32'd0);
    @(posedge clk); #1;
`endif

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
`ifdef MISALIGN_TRAP_EN
      if (size_of(f3) == 2) a[0] = 1'b0;
      if (size_of(f3) == 4) a[1:0] = 2'b00;
`endif
      case ($urandom_range(0, 2))
        0: begin
          @(negedge clk);
          check("rand nonmem pc", 32'(pc_enable), 32'd1);
          @(posedge clk); #1;
        end
        1: access(1'b1, 1'($urandom_range(0, 3) == 0), f3, a, $urandom,
                  ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5)), $urandom,
                  "rand_ld");
        default: access(1'b0, 1'b1, f3, a, $urandom, int'($urandom_range(0, 3)), $urandom,
                        "rand_st");
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
